// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage with loadable instruction memory,
// IF/ID pipeline register and LOAD/RUN/HALTED run-control FSM.
module if_stage #(
  parameter int                  NB_data   = 32,
  parameter int                  NB_addr   = 5,
  parameter logic [NB_data-1:0]  HALT_WORD = '1,
  parameter logic [NB_data-1:0]  NOP_WORD  = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_start,
  input  logic               in_enable,
  input  logic               in_stall,
  input  logic               in_flush,
  input  logic               in_branch_taken,
  input  logic [NB_data-1:0] in_branch,
  input  logic               in_load_we,
  input  logic [NB_addr-1:0] in_load_addr,
  input  logic [NB_data-1:0] in_load_data,
  output logic [NB_data-1:0] out_instruction,
  output logic [NB_data-1:0] out_branch,
  output logic [NB_data-1:0] out_pc,
  output logic               out_valid,
  output logic               out_halted
);
  typedef enum logic [1:0] {LOAD, RUN, HALTED} state_t;
  state_t             state_q, state_d;
  logic [NB_data-1:0] pc_q, pc_d, ins_q, ins_d, br_q, br_d;
  logic               val_q, val_d;
  logic [NB_data-1:0] mem [2**NB_addr];
  logic [NB_data-1:0] fetch_w, pc_inc, br_tgt;
  assign fetch_w = mem[pc_q[NB_addr+1:2]];
  assign pc_inc  = pc_q + NB_data'(4);
  assign br_tgt  = {in_branch[NB_data-1:2], 2'b00};
  // Program memory is deliberately not reset so a reset keeps the loaded image.
  always_ff @(posedge clk)
    if (state_q == LOAD && in_load_we) mem[in_load_addr] <= in_load_data;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    br_d    = br_q;
    val_d   = val_q;
    if (state_q == LOAD) begin
      pc_d  = '0;
      ins_d = NOP_WORD;
      br_d  = '0;
      val_d = 1'b0;
      if (in_start) state_d = RUN;
    end else if (in_enable) begin
      if (in_branch_taken) begin
        pc_d    = br_tgt;
        ins_d   = NOP_WORD;
        br_d    = '0;
        val_d   = 1'b0;
        state_d = RUN;
      end else if (in_flush || (state_q == HALTED && !in_stall)) begin
        ins_d = NOP_WORD;
        br_d  = '0;
        val_d = 1'b0;
        pc_d  = (state_q == RUN) ? pc_inc : pc_q;
      end else if (!in_stall) begin
        ins_d   = fetch_w;
        br_d    = pc_inc;
        val_d   = 1'b1;
        pc_d    = (fetch_w == HALT_WORD) ? pc_q : pc_inc;
        state_d = (fetch_w == HALT_WORD) ? HALTED : RUN;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= LOAD;
      pc_q    <= '0;
      ins_q   <= NOP_WORD;
      br_q    <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      br_q    <= br_d;
      val_q   <= val_d;
    end
  assign out_instruction = ins_q;
  assign out_branch      = br_q;
  assign out_pc          = pc_q;
  assign out_valid       = val_q;
  assign out_halted      = (state_q == HALTED);
endmodule
